// File: rtl/snitch_barrier_unit.sv
// -----------------------------------------------------------------------------
// snitch_barrier_unit
//
// Multi-barrier synchronisation unit for the Snitch cluster. NrBarriers
// independent barriers, each with its own participant mask. A barrier releases
// once every core in its mask is waiting on it. Each core raises a level
// request carrying a barrier ID and gets a one-cycle ack (optionally qualified
// by err) when the barrier releases or the request is rejected.
//
// Handshake: a core holds req_i (and id_i) high until it sees ack_o. In the
// cycle where ack_o is high, req_i is ignored. If req_i is still high in the
// following cycle, that counts as a new request.
//
// Ports
//   clk_i       cluster clock
//   rst_ni      asynchronous active-low reset
//   req_i       per-core barrier request (level)
//   id_i        per-core barrier ID, core i at [i*IdWidth +: IdWidth]
//   ack_o       per-core completion pulse (registered)
//   err_o       qualifies ack_o: the request was illegal
//   cfg_we_i    mask write strobe
//   cfg_id_i    barrier to configure (out-of-range writes are dropped)
//   cfg_mask_i  new participant mask
//   mask_o      participant masks, barrier b at [b*NrCores +: NrCores]
//   cnt_o       release counters, barrier b at [b*CntWidth +: CntWidth]
// -----------------------------------------------------------------------------
module snitch_barrier_unit #(
    parameter int unsigned NrCores    = 8,
    parameter int unsigned NrBarriers = 4,
    parameter int unsigned CntWidth   = 8,
    localparam int unsigned IdWidth   = (NrBarriers > 1) ? $clog2(NrBarriers) : 1
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NrCores-1:0]             req_i,
    input  logic [NrCores*IdWidth-1:0]     id_i,
    output logic [NrCores-1:0]             ack_o,
    output logic [NrCores-1:0]             err_o,
    input  logic                           cfg_we_i,
    input  logic [IdWidth-1:0]             cfg_id_i,
    input  logic [NrCores-1:0]             cfg_mask_i,
    output logic [NrBarriers*NrCores-1:0]  mask_o,
    output logic [NrBarriers*CntWidth-1:0] cnt_o
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } core_state_e;

    // Per-core FSM state; visible by name for checkers.
    core_state_e          state_q [NrCores];
    core_state_e          state_d [NrCores];
    logic [IdWidth-1:0]   wid_q   [NrCores];
    logic [IdWidth-1:0]   wid_d   [NrCores];
    logic [NrCores-1:0]   ack_q, ack_d;
    logic [NrCores-1:0]   err_q, err_d;

    logic [NrCores-1:0]   mask_q  [NrBarriers];
    logic [CntWidth-1:0]  cnt_q   [NrBarriers];

    logic [NrCores-1:0]   arr     [NrBarriers];
    logic [NrBarriers-1:0] release_b;
    // Per core: its waited-on barrier releases / its requested barrier admits it.
    logic [NrCores-1:0]   core_release;
    logic [NrCores-1:0]   core_legal;

    // Arrival and release are evaluated on registered state only, so there is
    // no path from the request inputs to the release decision.
    always_comb begin
        for (int b = 0; b < NrBarriers; b++) begin
            arr[b] = '0;
            for (int i = 0; i < NrCores; i++) begin
                arr[b][i] = (state_q[i] == WAIT) && (wid_q[i] == IdWidth'(b));
            end
            release_b[b] = (|mask_q[b]) && ((arr[b] & mask_q[b]) == mask_q[b]);
        end
    end

    // The mask lookup is done by matching against every valid barrier, so an
    // out-of-range ID simply finds no mask and is illegal.
    always_comb begin
        core_release = '0;
        core_legal   = '0;
        for (int i = 0; i < NrCores; i++) begin
            for (int b = 0; b < NrBarriers; b++) begin
                if (wid_q[i] == IdWidth'(b) && release_b[b]) begin
                    core_release[i] = 1'b1;
                end
                if (id_i[i*IdWidth +: IdWidth] == IdWidth'(b) && mask_q[b][i]) begin
                    core_legal[i] = 1'b1;
                end
            end
        end
    end

    // Per-core next state.
    always_comb begin
        ack_d = '0;
        err_d = '0;
        for (int i = 0; i < NrCores; i++) begin
            state_d[i] = state_q[i];
            wid_d[i]   = wid_q[i];
            unique case (state_q[i])
                IDLE: begin
                    if (req_i[i] && !ack_q[i]) begin
                        if (core_legal[i]) begin
                            state_d[i] = WAIT;
                            wid_d[i]   = id_i[i*IdWidth +: IdWidth];
                        end else begin
                            ack_d[i] = 1'b1;
                            err_d[i] = 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (core_release[i]) begin
                        state_d[i] = IDLE;
                        ack_d[i]   = 1'b1;
                    end
                end
                default: state_d[i] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NrCores; i++) begin
                state_q[i] <= IDLE;
                wid_q[i]   <= '0;
            end
            ack_q <= '0;
            err_q <= '0;
        end else begin
            for (int i = 0; i < NrCores; i++) begin
                state_q[i] <= state_d[i];
                wid_q[i]   <= wid_d[i];
            end
            ack_q <= ack_d;
            err_q <= err_d;
        end
    end

    // Masks reset to all ones so barrier 0 acts as the classic all-cores
    // barrier. A write lands at the edge and governs release from the next
    // cycle; legality in the write cycle still sees the old mask.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int b = 0; b < NrBarriers; b++) begin
                mask_q[b] <= '1;
                cnt_q[b]  <= '0;
            end
        end else begin
            for (int b = 0; b < NrBarriers; b++) begin
                if (release_b[b]) begin
                    cnt_q[b] <= cnt_q[b] + CntWidth'(1);
                end
                if (cfg_we_i && cfg_id_i == IdWidth'(b)) begin
                    mask_q[b] <= cfg_mask_i;
                end
            end
        end
    end

    always_comb begin
        for (int b = 0; b < NrBarriers; b++) begin
            mask_o[b*NrCores +: NrCores]   = mask_q[b];
            cnt_o[b*CntWidth +: CntWidth]  = cnt_q[b];
        end
    end

    assign ack_o = ack_q;
    assign err_o = err_q;

endmodule

// File: tb/tb_snitch_barrier_unit.sv
// -----------------------------------------------------------------------------
// tb_snitch_barrier_unit
//
// Bench for snitch_barrier_unit with 8 cores, 3 barriers (so ID 3 is out of
// range) and 2-bit counters (so wrap is reachable quickly). A behavioural model
// tracks, per core, whether it waits and on which barrier, plus masks and
// counters; a negedge process compares every output against it each cycle.
// Directed scenarios add literal expectations on top.
// -----------------------------------------------------------------------------
module tb_snitch_barrier_unit;

    localparam int NC = 8;
    localparam int NB = 3;
    localparam int CW = 2;
    localparam int IW = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    logic [NC-1:0]    req;
    logic [IW-1:0]    id [NC];
    logic [NC*IW-1:0] id_flat;
    logic [NC-1:0]    ack_o, err_o;
    logic             cfg_we;
    logic [IW-1:0]    cfg_id;
    logic [NC-1:0]    cfg_mask;
    logic [NB*NC-1:0] mask_o;
    logic [NB*CW-1:0] cnt_o;

    always_comb begin
        for (int i = 0; i < NC; i++) id_flat[i*IW +: IW] = id[i];
    end

    snitch_barrier_unit #(
        .NrCores    (NC),
        .NrBarriers (NB),
        .CntWidth   (CW)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .req_i      (req),
        .id_i       (id_flat),
        .ack_o      (ack_o),
        .err_o      (err_o),
        .cfg_we_i   (cfg_we),
        .cfg_id_i   (cfg_id),
        .cfg_mask_i (cfg_mask),
        .mask_o     (mask_o),
        .cnt_o      (cnt_o)
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit            m_wait [NC];
    int            m_wid  [NC];
    logic [NC-1:0] m_ack, m_err;
    logic [NC-1:0] m_mask [NB];
    int            m_cnt  [NB];

    task automatic model_reset();
        for (int i = 0; i < NC; i++) begin
            m_wait[i] = 1'b0;
            m_wid[i]  = 0;
        end
        m_ack = '0;
        m_err = '0;
        for (int b = 0; b < NB; b++) begin
            m_mask[b] = '1;
            m_cnt[b]  = 0;
        end
    endtask

    // One clock edge: uses the inputs that were stable before the edge.
    task automatic model_step();
        bit            rel [NB];
        bit            n_wait [NC];
        int            n_wid  [NC];
        logic [NC-1:0] n_ack, n_err;
        int            members, arrived, idv;
        for (int b = 0; b < NB; b++) begin
            members = 0;
            arrived = 0;
            for (int i = 0; i < NC; i++) begin
                if (m_mask[b][i]) begin
                    members++;
                    if (m_wait[i] && m_wid[i] == b) arrived++;
                end
            end
            rel[b] = (members > 0) && (arrived == members);
        end
        n_ack = '0;
        n_err = '0;
        for (int i = 0; i < NC; i++) begin
            n_wait[i] = m_wait[i];
            n_wid[i]  = m_wid[i];
            idv = int'(id[i]);
            if (m_wait[i]) begin
                if (rel[m_wid[i]]) begin
                    n_wait[i] = 1'b0;
                    n_ack[i]  = 1'b1;
                end
            end else if (req[i] && !m_ack[i]) begin
                if (idv < NB) begin
                    if (m_mask[idv][i]) begin
                        n_wait[i] = 1'b1;
                        n_wid[i]  = idv;
                    end else begin
                        n_ack[i] = 1'b1;
                        n_err[i] = 1'b1;
                    end
                end else begin
                    n_ack[i] = 1'b1;
                    n_err[i] = 1'b1;
                end
            end
        end
        for (int b = 0; b < NB; b++) begin
            if (rel[b]) m_cnt[b] = (m_cnt[b] + 1) % (1 << CW);
        end
        if (cfg_we && int'(cfg_id) < NB) m_mask[int'(cfg_id)] = cfg_mask;
        for (int i = 0; i < NC; i++) begin
            m_wait[i] = n_wait[i];
            m_wid[i]  = n_wid[i];
        end
        m_ack = n_ack;
        m_err = n_err;
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("ack", ack_o, m_ack);
            check("err", err_o, m_err);
            for (int b = 0; b < NB; b++) begin
                check($sformatf("mask%0d", b), mask_o[b*NC +: NC], m_mask[b]);
                check($sformatf("cnt%0d", b), cnt_o[b*CW +: CW], m_cnt[b]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    task automatic set_req(input logic [NC-1:0] r, input int idv);
        req = r;
        for (int i = 0; i < NC; i++) if (r[i]) id[i] = IW'(idv);
    endtask

    task automatic cfg_write(input int b, input logic [NC-1:0] m);
        cfg_we   = 1'b1;
        cfg_id   = IW'(b);
        cfg_mask = m;
        cyc();
        cfg_we   = 1'b0;
    endtask

    function automatic logic [CW-1:0] cnt_of(input int b);
        return cnt_o[b*CW +: CW];
    endfunction

    // ---------------- stimulus ----------------
    bit low_next [NC];

    initial begin
        rst_n    = 1'b0;
        req      = '0;
        cfg_we   = 1'b0;
        cfg_id   = '0;
        cfg_mask = '0;
        for (int i = 0; i < NC; i++) begin
            id[i] = '0;
            low_next[i] = 1'b0;
        end
        model_reset();
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_ack", ack_o, 0);
        check("rst_mask", mask_o, 24'hFFFFFF);
        check("rst_cnt", cnt_o, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1: all cores on barrier 0 at cycle 0 -> ack at cycle 2
        set_req(8'hFF, 0);
        cyc();
        check("t1_ack_c1", ack_o, 8'h00);
        cyc();
        check("t1_ack_c2", ack_o, 8'hFF);
        check("t1_err", err_o, 8'h00);
        check("t1_cnt0", cnt_of(0), 1);
        req = '0;
        cyc();

        // 2: staggered arrival, last core at cycle 7 -> ack at 9
        for (int k = 0; k < NC; k++) begin
            req[k] = 1'b1;
            id[k]  = '0;
            cyc();
            check($sformatf("t2_noack_c%0d", k + 1), ack_o, 8'h00);
        end
        cyc();
        check("t2_ack_c9", ack_o, 8'hFF);
        check("t2_cnt0", cnt_of(0), 2);
        req = '0;
        cyc();

        // 3: two disjoint barriers release together
        cfg_write(1, 8'h0F);
        cfg_write(2, 8'hF0);
        check("t3_mask1", mask_o[1*NC +: NC], 8'h0F);
        check("t3_mask2", mask_o[2*NC +: NC], 8'hF0);
        set_req(8'h0F, 1);
        set_req(8'hFF, 2);
        for (int i = 0; i < 4; i++) id[i] = IW'(1);
        cyc();
        cyc();
        check("t3_ack", ack_o, 8'hFF);
        check("t3_cnt1", cnt_of(1), 1);
        check("t3_cnt2", cnt_of(2), 1);
        req = '0;
        cyc();

        // 4: illegal requests: not in mask, and ID out of range
        set_req(8'h20, 1);
        cyc();
        check("t4_ack_mask", ack_o, 8'h20);
        check("t4_err_mask", err_o, 8'h20);
        req = '0;
        cyc();
        set_req(8'h20, 3);
        cyc();
        check("t4_ack_range", ack_o, 8'h20);
        check("t4_err_range", err_o, 8'h20);
        req = '0;
        cyc();

        // 5: shrink the mask to the already-arrived subset
        set_req(8'h07, 1);
        cyc();
        cyc();
        check("t5_noack", ack_o, 8'h00);
        cfg_write(1, 8'h07);
        cyc();
        check("t5_ack", ack_o, 8'h07);
        check("t5_err", err_o, 8'h00);
        check("t5_cnt1", cnt_of(1), 2);
        req = '0;
        cyc();

        // 6: counter wrap on barrier 0 (2 -> 3 -> 0)
        for (int r = 0; r < 2; r++) begin
            set_req(8'hFF, 0);
            cyc();
            cyc();
            check($sformatf("t6_ack%0d", r), ack_o, 8'hFF);
            req = '0;
            cyc();
        end
        check("t6_wrap", cnt_of(0), 0);

        // 6: reset while cores 0-3 wait on barrier 0
        set_req(8'h0F, 0);
        cyc();
        cyc();
        check("t6_wait_noack", ack_o, 8'h00);
        rst_n = 1'b0;
        req   = '0;
        model_reset();
        @(negedge clk);
        check("t6_rst_ack", ack_o, 8'h00);
        check("t6_rst_mask", mask_o, 24'hFFFFFF);
        check("t6_rst_cnt", cnt_o, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // If cores 0-3 had kept waiting, 4-7 alone would complete barrier 0.
        set_req(8'hF0, 0);
        cyc();
        cyc();
        cyc();
        check("t6_idle_after_rst", ack_o, 8'h00);
        set_req(8'hFF, 0);
        cyc();
        cyc();
        check("t6_rel_after_rst", ack_o, 8'hFF);
        req = '0;
        cyc();

        // Randomised traffic, checked by the compare process.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NC; i++) begin
                if (m_ack[i]) begin
                    req[i] = 1'($urandom_range(0, 1));
                    low_next[i] = 1'b1;
                end else if (low_next[i]) begin
                    req[i] = 1'b0;
                    low_next[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                    id[i]  = IW'($urandom_range(0, 3));
                end
            end
            if ($urandom_range(0, 15) == 0) begin
                cfg_we   = 1'b1;
                cfg_id   = IW'($urandom_range(0, 3));
                cfg_mask = ($urandom_range(0, 1) == 0) ? 8'hFF : NC'($urandom);
            end else begin
                cfg_we = 1'b0;
            end
            if (c == 1500) begin
                // Mid-traffic reset with arbitrary cores waiting.
                rst_n = 1'b0;
                req   = '0;
                cfg_we = 1'b0;
                for (int i = 0; i < NC; i++) low_next[i] = 1'b0;
                model_reset();
                @(posedge clk);
                #1;
                rst_n = 1'b1;
            end
            cyc();
        end

        req    = '0;
        cfg_we = 1'b0;
        cyc();
        @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
